tick_timeout_arbiter: RTL and testbench
=======================================

Name: tick_timeout_arbiter

Overview:
- Shares one 50 us tick prescaler and one timeout counter between NREQ requesters, for example the UART RX frame timer, the TX inter-frame gap and the break detector.
- Each requester asks for a timeout of LEN ticks.
- A round-robin arbiter grants the timer to one requester at a time, counts the ticks, and returns a one-cycle done pulse.
- Sits between the UART control FSMs and the timing base, replacing the per-FSM private timer instances.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TICK_DIV, 2500, clk cycles per tick (50 us at 50 MHz).
- LEN_W, 6, width of each requested tick count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  level request per requester; held until done, or dropped to abort.
- len  in  NREQ*LEN_W  flattened tick counts; requester i uses bits [i*LEN_W +: LEN_W]. Sampled only at grant.
- gnt  out  NREQ  one-hot owner of the timer; all zeros when idle.
- done  out  NREQ  one-hot, one-cycle pulse to the owner when its timeout expires.
- busy  out  1  high while in RUN or DONE.
- tick  out  1  one-cycle pulse for each prescaler wrap while in RUN (debug/observe).

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; gnt=0, done=0, busy=0, tick=0.
  - prescaler=0, cnt=0, rr_ptr=0, mask=0.
- All outputs are registered.
- State IDLE:
  - Eligible set = req & ~mask.
  - If the set is non-empty, pick the first requester at or after rr_ptr, wrapping modulo NREQ.
  - On the grant cycle: latch owner index and len_sel = that requester's len; gnt<=onehot(owner); prescaler<=0; cnt<=0; mask<=0.
  - Next state is RUN, or DONE if len_sel==0.
  - If no request is eligible: stay in IDLE and clear mask.
- State RUN:
  - Abort has priority over counting. If req[owner]==0, go to IDLE: gnt<=0, no done, rr_ptr<=owner+1.
  - Otherwise prescaler increments each cycle. At TICK_DIV-1 it wraps to 0, tick pulses and cnt<=cnt+1.
  - If cnt+1==len_sel on that wrap, go to DONE.
- State DONE (one cycle):
  - done[owner]=1 and gnt[owner] still 1; next cycle gnt<=0 and done<=0.
  - rr_ptr<=owner+1 mod NREQ; mask<=onehot(owner); next state is IDLE.
  - The mask excludes the old owner for exactly the first IDLE cycle, so a registered requester has one cycle to drop req.
  - If the old owner still holds req after that cycle, it is a new request and is treated as such.
- Timing, with G = the cycle after the grant decision (gnt first high):
  - The first tick lands at G+TICK_DIV-1.
  - done is high in cycle G+len*TICK_DIV.
  - len==0 gives done in cycle G.
- Arithmetic:
  - cnt is LEN_W bits. The maximum len (2^LEN_W-1) must complete without wrap; compare cnt+1 at LEN_W+1 bits.
  - prescaler width is clog2(TICK_DIV).
- len changing after grant has no effect; it is latched.
- Simultaneous requests are served in round-robin order starting at rr_ptr. No requester waits more than NREQ-1 full timeouts.
- rst asserted mid-RUN or mid-DONE: on the next edge all outputs go to 0 and no done is issued.
- req for an index that is not the owner changing during RUN is ignored until IDLE.

Decomposition:
- Shared package (uart_timing_pkg):
  - CLK_HZ=50_000_000, TICK_US=50, TICK_DIV derived from them.
  - State encoding localparams IDLE/RUN/DONE.
  - Requester index constants (RX_TO, TX_GAP, BRK, SPARE).
- One sub-module: tick_prescaler (clk, rst, clr, en, tick_o), a clearable mod-TICK_DIV counter. The arbiter and FSM stay in the top.

Test Plan:
- Single request: TICK_DIV=10, req[0]=1, len=3 -> gnt=0001 from G; done[0] high exactly at G+30 for one cycle; gnt=0 at G+31; tick pulses at G+9, G+19, G+29.
- Contention: req=1111 simultaneously with rr_ptr=0 -> grants in order 0,1,2,3; each done is spaced len*TICK_DIV+2 cycles apart; the old owner's req (still high for one cycle after its done) never causes a re-grant.
- Abort: req[2] dropped at G+15 with len=5 -> back in IDLE the next cycle; done never pulses; rr_ptr=3; a waiting req[3] is granted next.
- len=0 and len=63 on requester 1 -> done at G, respectively at G+63*TICK_DIV; no counter wrap.
- rst pulsed for one cycle during RUN at G+12 -> gnt, done, busy and tick are all 0 next cycle; a subsequent req[0] with len=2 times correctly from a fresh G.
- Fairness: req[0] held continuously and re-requests after every done, with req[1] also held -> grants alternate 0,1,0,1.

Source files
------------

// File: rtl/uart_timing_pkg.sv
// Shared timing constants, FSM state encoding and requester indices
// for the UART timing base and the shared timeout arbiter.
package uart_timing_pkg;

    localparam int CLK_HZ   = 50_000_000;
    localparam int TICK_US  = 50;
    localparam int TICK_DIV = (CLK_HZ / 1_000_000) * TICK_US;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    localparam int RX_TO  = 0;
    localparam int TX_GAP = 1;
    localparam int BRK    = 2;
    localparam int SPARE  = 3;

endpackage

// File: rtl/tick_timeout_arbiter_prescaler.sv
// tick_prescaler: clearable mod-TICK_DIV counter (TICK_DIV >= 2).
// Ports: clk, rst (sync, high), clr (restart at 0), en (count),
//        tick_o (registered, high in the cycle the counter wraps).
module tick_prescaler #(
    parameter int TICK_DIV = uart_timing_pkg::TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE  = PW'(TICK_DIV - 2);

    logic [PW-1:0] r_cnt;
    logic          r_tick;

    // tick is raised one count early so the registered pulse lines up
    // with the cycle in which the counter sits at LAST and wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            r_tick <= (r_cnt == PRE);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick_o = r_tick;

endmodule

// File: rtl/tick_timeout_arbiter.sv
// Round-robin shared timeout timer: grants one requester at a time,
// counts LEN ticks of the prescaler, then pulses done to the owner.
// Ports: clk, rst (sync, high); req[NREQ] level requests;
//        len[NREQ*LEN_W] per-requester tick counts (latched at grant);
//        gnt/done[NREQ] one-hot owner / expiry pulse; busy; tick.
module tick_timeout_arbiter #(
    parameter int NREQ     = 4,
    parameter int TICK_DIV = uart_timing_pkg::TICK_DIV,
    parameter int LEN_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  tick
);

    import uart_timing_pkg::*;

    localparam int IW = $clog2(NREQ);

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [IW-1:0]    w_pick, w_owner_inc;
    logic [LEN_W-1:0] r_len, w_len_nxt, w_len_pick;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic [LEN_W:0]   w_cnt_inc;
    logic [NREQ-1:0]  r_mask, w_mask_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]  r_done, w_done_nxt;
    logic [NREQ-1:0]  w_elig;
    logic             r_busy, w_busy_nxt;
    logic             w_found, w_clr, w_en, w_tick;

    assign w_elig      = req & ~r_mask;
    assign w_len_pick  = len[int'(w_pick)*LEN_W +: LEN_W];
    assign w_owner_inc = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
    // one extra bit so len = 2^LEN_W-1 completes without wrapping
    assign w_cnt_inc   = {1'b0, r_cnt} + (LEN_W + 1)'(1);
    assign w_en        = (r_state == RUN) && req[r_owner];

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .tick_o(w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_busy_nxt  = r_busy;
        w_clr       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_mask_nxt = '0;
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_len_nxt   = w_len_pick;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = NREQ'(1) << w_pick;
                    w_busy_nxt  = 1'b1;
                    w_clr       = 1'b1;
                    if (w_len_pick == '0) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = NREQ'(1) << w_pick;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (!req[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = w_owner_inc;
                end else if (w_tick) begin
                    w_cnt_nxt = w_cnt_inc[LEN_W-1:0];
                    if (w_cnt_inc == {1'b0, r_len}) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = r_gnt;
                    end
                end
            end
            DONE: begin
                // old owner is masked for one IDLE cycle so it can drop req
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = w_owner_inc;
                w_mask_nxt  = r_gnt;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign tick = w_tick;

endmodule

// File: tb/tb_tick_timeout_arbiter.sv
// Self-checking bench for tick_timeout_arbiter (NREQ=4, TICK_DIV=10).
// Expected done pulses are queued at stimulus time and popped on output.
module tb_tick_timeout_arbiter;

    localparam int TD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [23:0] len = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        tick;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    tick_timeout_arbiter #(
        .NREQ    (4),
        .TICK_DIV(TD),
        .LEN_W   (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .len (len),
        .gnt (gnt),
        .done(done),
        .busy(busy),
        .tick(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        req = 4'hF;
        len = {4{6'd1}};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== 4'b0) begin
            failures++;
            $display("FAIL reset_gnt got=%b want=0000", gnt);
        end
        checks++;
        if (done !== 4'b0) begin
            failures++;
            $display("FAIL reset_done got=%b want=0000", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick got=%b want=0", tick);
        end
        rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int g, k;
        logic [3:0] eg;
        logic et;
        len[0 +: 6] = 6'd3;
        @(negedge clk);
        req = 4'b0001;
        g = cyc + 1;
        exp_q.push_back(exp_t'{g + 3 * TD, 4'b0001});
        do begin
            @(negedge clk);
            k = cyc - g;
            if (k == 32) req[0] = 1'b0;
            eg = (k <= 30) ? 4'b0001 : 4'b0000;
            et = (k == 9 || k == 19 || k == 29);
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL single_gnt k=%0d got=%b want=%b", k, gnt, eg);
            end
            checks++;
            if (busy !== (eg != 0)) begin
                failures++;
                $display("FAIL single_busy k=%0d got=%b", k, busy);
            end
            checks++;
            if (tick !== et) begin
                failures++;
                $display("FAIL single_tick k=%0d got=%b want=%b", k, tick, et);
            end
            if (done !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL single_done_unexp cyc=%0d got=%b", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== done) begin
                        failures++;
                        $display("FAIL single_done got cyc=%0d %b want cyc=%0d %b",
                                 cyc, done, e.cyc, e.vec);
                    end
                end
            end
        end while (k < 36);
    endtask

    task automatic test_contention();
        int g, k;
        int drop_at[4];
        logic [3:0] eg;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            len[i*6 +: 6] = 6'd2;
            drop_at[i] = -1;
        end
        @(negedge clk);
        req = 4'hF;
        g = cyc + 1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(exp_t'{g + 20 + 22 * i, 4'(1 << i)});
        do begin
            @(negedge clk);
            k = cyc - g;
            for (int i = 0; i < 4; i++) begin
                if (k == drop_at[i]) req[i] = 1'b0;
                if (done[i] === 1'b1) drop_at[i] = k + 2;
            end
            eg = '0;
            for (int i = 0; i < 4; i++)
                if (k >= 22 * i && k <= 22 * i + 20) eg = 4'(1 << i);
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL cont_gnt k=%0d got=%b want=%b", k, gnt, eg);
            end
            if (done !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL cont_done_unexp cyc=%0d got=%b", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== done) begin
                        failures++;
                        $display("FAIL cont_done got cyc=%0d %b want cyc=%0d %b",
                                 cyc, done, e.cyc, e.vec);
                    end
                end
            end
        end while (k < 94);
    endtask

    task automatic test_abort();
        int g, k;
        logic [3:0] eg;
        logic et;
        len[0*6 +: 6] = 6'd1;
        len[2*6 +: 6] = 6'd5;
        len[3*6 +: 6] = 6'd1;
        @(negedge clk);
        req = 4'b1100;
        g = cyc + 1;
        exp_q.push_back(exp_t'{g + 27, 4'b1000});
        exp_q.push_back(exp_t'{g + 39, 4'b0001});
        do begin
            @(negedge clk);
            k = cyc - g;
            if (k == 15) begin
                req[2] = 1'b0;
                req[0] = 1'b1;
            end
            if (k == 29) req[3] = 1'b0;
            if (k == 41) req[0] = 1'b0;
            if (k <= 15)                eg = 4'b0100;
            else if (k >= 17 && k <= 27) eg = 4'b1000;
            else if (k >= 29 && k <= 39) eg = 4'b0001;
            else                         eg = 4'b0000;
            et = (k == 9 || k == 26 || k == 38);
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL abort_gnt k=%0d got=%b want=%b", k, gnt, eg);
            end
            checks++;
            if (tick !== et) begin
                failures++;
                $display("FAIL abort_tick k=%0d got=%b want=%b", k, tick, et);
            end
            if (done !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL abort_done_unexp cyc=%0d got=%b", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== done) begin
                        failures++;
                        $display("FAIL abort_done got cyc=%0d %b want cyc=%0d %b",
                                 cyc, done, e.cyc, e.vec);
                    end
                end
            end
        end while (k < 45);
    endtask

    task automatic test_len_edges();
        int g, k, nt;
        logic [3:0] eg;
        logic et;
        len[1*6 +: 6] = 6'd0;
        @(negedge clk);
        req = 4'b0010;
        g = cyc + 1;
        exp_q.push_back(exp_t'{g, 4'b0010});
        nt = 0;
        do begin
            @(negedge clk);
            k = cyc - g;
            if (k == 2) req[1] = 1'b0;
            eg = (k == 0) ? 4'b0010 : 4'b0000;
            checks++;
            if (gnt !== eg || busy !== (k == 0) || tick !== 1'b0) begin
                failures++;
                $display("FAIL len0_out k=%0d gnt=%b busy=%b tick=%b want gnt=%b",
                         k, gnt, busy, tick, eg);
            end
            if (done !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL len0_done_unexp cyc=%0d got=%b", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== done) begin
                        failures++;
                        $display("FAIL len0_done got cyc=%0d %b want cyc=%0d %b",
                                 cyc, done, e.cyc, e.vec);
                    end
                end
            end
        end while (k < 5);
        len[1*6 +: 6] = 6'd63;
        @(negedge clk);
        req = 4'b0010;
        g = cyc + 1;
        exp_q.push_back(exp_t'{g + 63 * TD, 4'b0010});
        do begin
            @(negedge clk);
            k = cyc - g;
            if (k == 5) len[1*6 +: 6] = 6'd1;
            if (k == 632) req[1] = 1'b0;
            eg = (k <= 630) ? 4'b0010 : 4'b0000;
            et = (k < 630) && (k % TD == TD - 1);
            if (tick === 1'b1) nt++;
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL len63_gnt k=%0d got=%b want=%b", k, gnt, eg);
            end
            checks++;
            if (tick !== et) begin
                failures++;
                $display("FAIL len63_tick k=%0d got=%b want=%b", k, tick, et);
            end
            if (done !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL len63_done_unexp cyc=%0d got=%b", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== done) begin
                        failures++;
                        $display("FAIL len63_done got cyc=%0d %b want cyc=%0d %b",
                                 cyc, done, e.cyc, e.vec);
                    end
                end
            end
        end while (k < 636);
        checks++;
        if (nt != 63) begin
            failures++;
            $display("FAIL len63_ticks got=%0d want=63", nt);
        end
    endtask

    task automatic test_rst_mid();
        int g, k;
        logic [3:0] eg;
        logic et;
        len[0 +: 6] = 6'd5;
        @(negedge clk);
        req = 4'b0001;
        g = cyc + 1;
        exp_q.push_back(exp_t'{g + 14 + 2 * TD, 4'b0001});
        do begin
            @(negedge clk);
            k = cyc - g;
            if (k == 12) begin
                rst = 1'b1;
                len[0 +: 6] = 6'd2;
            end
            if (k == 13) begin
                rst = 1'b0;
                checks++;
                if (gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || tick !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_outs gnt=%b done=%b busy=%b tick=%b want all 0",
                             gnt, done, busy, tick);
                end
            end
            if (k == 36) req[0] = 1'b0;
            if (k <= 12)                 eg = 4'b0001;
            else if (k >= 14 && k <= 34) eg = 4'b0001;
            else                         eg = 4'b0000;
            et = (k == 9 || k == 23 || k == 33);
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL rstmid_gnt k=%0d got=%b want=%b", k, gnt, eg);
            end
            checks++;
            if (tick !== et) begin
                failures++;
                $display("FAIL rstmid_tick k=%0d got=%b want=%b", k, tick, et);
            end
            if (done !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rstmid_done_unexp cyc=%0d got=%b", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== done) begin
                        failures++;
                        $display("FAIL rstmid_done got cyc=%0d %b want cyc=%0d %b",
                                 cyc, done, e.cyc, e.vec);
                    end
                end
            end
        end while (k < 40);
    endtask

    task automatic test_fairness();
        int g, k;
        logic [3:0] eg;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        len[0*6 +: 6] = 6'd1;
        len[1*6 +: 6] = 6'd1;
        @(negedge clk);
        req = 4'b0011;
        g = cyc + 1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(exp_t'{g + 10 + 12 * i, (i % 2 == 0) ? 4'b0001 : 4'b0010});
        do begin
            @(negedge clk);
            k = cyc - g;
            if (k == 46) req = 4'b0000;
            if (k < 48 && (k % 12) <= 10)
                eg = ((k / 12) % 2 == 0) ? 4'b0001 : 4'b0010;
            else
                eg = 4'b0000;
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL fair_gnt k=%0d got=%b want=%b", k, gnt, eg);
            end
            if (done !== 4'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL fair_done_unexp cyc=%0d got=%b", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== done) begin
                        failures++;
                        $display("FAIL fair_done got cyc=%0d %b want cyc=%0d %b",
                                 cyc, done, e.cyc, e.vec);
                    end
                end
            end
        end while (k < 52);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_len_edges();
        test_rst_mid();
        test_fairness();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_done got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
